// File: rtl/vote_display_ctrl_if.sv
// Bus between the vote-counter bank / board buttons and the LED display
// controller.
//   master : drives mode, valid_vote, cand_votes, cand_btn;
//            observes leds, busy, leader_idx, leader_valid
//   slave  : the display controller (mirror image of master)
interface vote_display_ctrl_if #(
  parameter int NUM_CAND = 4,
  parameter int CNT_W    = 8,
  parameter int LED_W    = 8
);
  localparam int IDX_W = $clog2(NUM_CAND);

  logic                      mode;        // 0 vote mode, 1 result mode
  logic                      valid_vote;  // 1-cycle pulse per accepted vote
  logic [NUM_CAND*CNT_W-1:0] cand_votes;  // cand i at [i*CNT_W +: CNT_W]
  logic [NUM_CAND-1:0]       cand_btn;    // debounced level buttons
  logic [LED_W-1:0]          leds;
  logic                      busy;
  logic [IDX_W-1:0]          leader_idx;
  logic                      leader_valid;

  modport master (
    output mode, valid_vote, cand_votes, cand_btn,
    input  leds, busy, leader_idx, leader_valid
  );

  modport slave (
    input  mode, valid_vote, cand_votes, cand_btn,
    output leds, busy, leader_idx, leader_valid
  );
endinterface

// File: rtl/vote_display_ctrl.sv
// LED display controller for the voting machine.
//   Vote mode  : after each valid_vote the LEDs flash all-ones for HOLD_CYCLES
//                cycles (retriggerable); busy is high during the flash.
//   Result mode: LEDs show the tally of the lowest-index pressed candidate
//                button, saturated to LED_W bits; held when buttons released.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-low reset
//   bus   vote_display_ctrl_if.slave (mode, valid_vote, cand_votes, cand_btn
//         in; leds, busy, leader_idx, leader_valid out, all registered)
// Build option: define LEADER_DISP_EN to add a round-robin leader scanner;
// in result mode, before any button is pressed, the leader's tally is shown.
// Without it leader_idx/leader_valid are tied to 0.
module vote_display_ctrl #(
  parameter int NUM_CAND    = 4,
  parameter int CNT_W       = 8,
  parameter int LED_W       = 8,
  parameter int HOLD_CYCLES = 100000000
) (
  input  logic               clk,
  input  logic               rst,
  vote_display_ctrl_if.slave bus
);
  localparam int IDX_W  = $clog2(NUM_CAND);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int SAT_W  = (CNT_W > LED_W) ? CNT_W : LED_W;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACK, RESULT} state_e;

  state_e            state_q;
  logic [HOLD_W-1:0] hold_q;
  logic [LED_W-1:0]  leds_q;
  logic              busy_q;
  logic              seen_q;     // a button was pressed since entering RESULT
  logic [IDX_W-1:0]  leader_idx_q;
  logic              leader_valid_q;

  // Widen to the larger of the two widths, then clamp: covers both the
  // zero-extend case (never exceeds the clamp) and the saturating case.
  function automatic logic [LED_W-1:0] sat(input logic [CNT_W-1:0] t);
    logic [SAT_W-1:0] w;
    w = SAT_W'(t);
    if (w > SAT_W'({LED_W{1'b1}})) return '1;
    return w[LED_W-1:0];
  endfunction

  // Lowest pressed index wins: descending loop so index 0 is assigned last.
  logic [CNT_W-1:0] btn_tally;
  logic             any_btn;
  always_comb begin
    btn_tally = '0;
    for (int i = NUM_CAND - 1; i >= 0; i--)
      if (bus.cand_btn[i]) btn_tally = bus.cand_votes[i*CNT_W +: CNT_W];
  end
  assign any_btn = |bus.cand_btn;

`ifdef LEADER_DISP_EN
  // One candidate per cycle; best-so-far restarts at index 0 of each sweep
  // and strict '>' keeps ties on the lowest index.
  logic [IDX_W-1:0] scan_q, best_idx_q, best_idx_d;
  logic [CNT_W-1:0] best_val_q, best_val_d, cur_val;
  logic             scan_last;

  assign cur_val   = bus.cand_votes[int'(scan_q)*CNT_W +: CNT_W];
  assign scan_last = (scan_q == IDX_W'(NUM_CAND - 1));

  always_comb begin
    best_idx_d = best_idx_q;
    best_val_d = best_val_q;
    if (scan_q == '0 || cur_val > best_val_q) begin
      best_idx_d = scan_q;
      best_val_d = cur_val;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_q         <= '0;
      best_idx_q     <= '0;
      best_val_q     <= '0;
      leader_idx_q   <= '0;
      leader_valid_q <= 1'b0;
    end else begin
      best_idx_q <= best_idx_d;
      best_val_q <= best_val_d;
      if (scan_last) begin
        scan_q         <= '0;
        leader_idx_q   <= best_idx_d;
        leader_valid_q <= (best_val_d != '0);
      end else begin
        scan_q <= scan_q + 1'b1;
      end
    end
  end

  logic [LED_W-1:0] leader_disp;
  assign leader_disp = sat(bus.cand_votes[int'(leader_idx_q)*CNT_W +: CNT_W]);
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      leader_idx_q   <= '0;
      leader_valid_q <= 1'b0;
    end else begin
      leader_idx_q   <= '0;
      leader_valid_q <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      leds_q  <= '0;
      busy_q  <= 1'b0;
      seen_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          leds_q <= '0;
          busy_q <= 1'b0;
          // mode check first: a simultaneous vote is dropped
          if (bus.mode) begin
            state_q <= RESULT;
            seen_q  <= 1'b0;
          end else if (bus.valid_vote) begin
            state_q <= ACK;
            hold_q  <= HOLD_LOAD;
            leds_q  <= '1;
            busy_q  <= 1'b1;
          end
        end
        ACK: begin
          if (bus.mode) begin
            state_q <= RESULT;
            hold_q  <= '0;
            leds_q  <= '0;
            busy_q  <= 1'b0;
            seen_q  <= 1'b0;
          end else if (bus.valid_vote) begin
            hold_q <= HOLD_LOAD;
          end else if (hold_q == '0) begin
            state_q <= IDLE;
            leds_q  <= '0;
            busy_q  <= 1'b0;
          end else begin
            hold_q <= hold_q - 1'b1;
          end
        end
        RESULT: begin
          busy_q <= 1'b0;
          if (!bus.mode) begin
            state_q <= IDLE;
            leds_q  <= '0;
          end else if (any_btn) begin
            leds_q <= sat(btn_tally);
            seen_q <= 1'b1;
          end
`ifdef LEADER_DISP_EN
          else if (!seen_q) begin
            leds_q <= leader_disp;
          end
`endif
        end
        default: begin
          state_q <= IDLE;
          leds_q  <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.leds         = leds_q;
  assign bus.busy         = busy_q;
  assign bus.leader_idx   = leader_idx_q;
  assign bus.leader_valid = leader_valid_q;
endmodule

// File: tb/tb_vote_display_ctrl.sv
module tb_vote_display_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // main instance: 4 candidates, 8-bit tallies, 5-cycle flash
  vote_display_ctrl_if #(.NUM_CAND(4), .CNT_W(8), .LED_W(8)) bus ();
  vote_display_ctrl #(.NUM_CAND(4), .CNT_W(8), .LED_W(8), .HOLD_CYCLES(5))
    dut (.clk(clk), .rst(rst), .bus(bus));

  // saturation instance: 10-bit tallies onto 8 LEDs
  vote_display_ctrl_if #(.NUM_CAND(2), .CNT_W(10), .LED_W(8)) bus_s ();
  vote_display_ctrl #(.NUM_CAND(2), .CNT_W(10), .LED_W(8), .HOLD_CYCLES(5))
    dut_s (.clk(clk), .rst(rst), .bus(bus_s));

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      tag;
    logic [7:0] leds;
    logic       busy;
  } exp_t;
  exp_t sbq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Inputs are already driven (we sit at a negedge); push the expectation,
  // let the DUT take one edge, then pop and compare its registered outputs.
  task automatic cyc(input logic [7:0] el, input logic eb, input string tag);
    exp_t e;
    sbq.push_back('{tag: tag, leds: el, busy: eb});
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk({e.tag, ".leds"}, 32'(bus.leds), 32'(e.leds));
    chk({e.tag, ".busy"}, 32'(bus.busy), 32'(e.busy));
    @(negedge clk);
  endtask

  task automatic sat_chk(input logic [9:0] t0, input logic [1:0] btn,
                         input logic [7:0] el, input string tag);
    bus_s.cand_votes[9:0] = t0;
    bus_s.cand_btn        = btn;
    @(posedge clk);
    #1;
    chk(tag, 32'(bus_s.leds), 32'(el));
    @(negedge clk);
  endtask

  logic [7:0] entry_leds;

  initial begin
    rst = 1'b0;
    bus.mode = 1'b0; bus.valid_vote = 1'b0; bus.cand_votes = '0; bus.cand_btn = '0;
    bus_s.mode = 1'b0; bus_s.valid_vote = 1'b0; bus_s.cand_votes = '0; bus_s.cand_btn = '0;
    repeat (2) @(negedge clk);
    chk("rst.leds", 32'(bus.leds), 0);
    chk("rst.busy", 32'(bus.busy), 0);
    chk("rst.lidx", 32'(bus.leader_idx), 0);
    chk("rst.lval", 32'(bus.leader_valid), 0);
    rst = 1'b1;
    cyc(8'h00, 1'b0, "idle");

    // single flash: 5 cycles of all-ones then dark
    bus.valid_vote = 1'b1;
    cyc(8'hFF, 1'b1, "ack1.0");
    bus.valid_vote = 1'b0;
    for (int i = 1; i < 5; i++) cyc(8'hFF, 1'b1, $sformatf("ack1.%0d", i));
    cyc(8'h00, 1'b0, "ack1.end");
    cyc(8'h00, 1'b0, "ack1.idle");

    // retrigger at t+3 extends to t+8
    bus.valid_vote = 1'b1;
    cyc(8'hFF, 1'b1, "rtg.0");
    bus.valid_vote = 1'b0;
    cyc(8'hFF, 1'b1, "rtg.1");
    cyc(8'hFF, 1'b1, "rtg.2");
    bus.valid_vote = 1'b1;
    cyc(8'hFF, 1'b1, "rtg.3");
    bus.valid_vote = 1'b0;
    for (int i = 4; i < 8; i++) cyc(8'hFF, 1'b1, $sformatf("rtg.%0d", i));
    cyc(8'h00, 1'b0, "rtg.end");

    // async reset in the middle of a flash
    bus.valid_vote = 1'b1;
    cyc(8'hFF, 1'b1, "rack.0");
    bus.valid_vote = 1'b0;
    cyc(8'hFF, 1'b1, "rack.1");
    rst = 1'b0;
    #1;
    chk("rack.leds", 32'(bus.leds), 0);
    chk("rack.busy", 32'(bus.busy), 0);
    @(negedge clk);
    rst = 1'b1;
    cyc(8'h00, 1'b0, "rack.idle");
    bus.valid_vote = 1'b1;
    cyc(8'hFF, 1'b1, "rack.vote");
    bus.valid_vote = 1'b0;
    // mode change aborts the flash
    bus.mode = 1'b1;
    cyc(8'h00, 1'b0, "abort");
    bus.mode = 1'b0;
    cyc(8'h00, 1'b0, "abort.idle");

    // result mode; tallies cand0..3 = 12,3,7,9; let the scanner settle first
    bus.cand_votes = {8'd9, 8'd7, 8'd3, 8'd12};
    for (int i = 0; i < 10; i++) cyc(8'h00, 1'b0, "settle");
`ifdef LEADER_DISP_EN
    entry_leds = 8'd12;
`else
    entry_leds = 8'd0;
`endif
    bus.mode = 1'b1;
    cyc(8'h00, 1'b0, "res.entry");
    cyc(entry_leds, 1'b0, "res.nobtn");
    bus.cand_btn = 4'b0110;
    cyc(8'd3, 1'b0, "res.b12");
    bus.cand_btn = 4'b0000;
    cyc(8'd3, 1'b0, "res.hold0");
    cyc(8'd3, 1'b0, "res.hold1");
    bus.cand_btn = 4'b1000;
    cyc(8'd9, 1'b0, "res.b3");
    bus.cand_btn = 4'b1111;
    cyc(8'd12, 1'b0, "res.all");
    bus.cand_btn = 4'b0000;
    bus.valid_vote = 1'b1;
    cyc(8'd12, 1'b0, "res.voteign");
    bus.valid_vote = 1'b0;
    bus.mode = 1'b0;
    cyc(8'h00, 1'b0, "res.exit");
    // vote and mode rise together: mode wins, no flash
    bus.mode = 1'b1;
    bus.valid_vote = 1'b1;
    cyc(8'h00, 1'b0, "race");
    bus.valid_vote = 1'b0;
    cyc(entry_leds, 1'b0, "race.res");
    bus.mode = 1'b0;
    cyc(8'h00, 1'b0, "race.exit");

    // saturation on the 10-bit instance
    bus_s.cand_votes[19:10] = 10'd200;
    bus_s.mode = 1'b1;
    sat_chk(10'd300, 2'b00, 8'h00, "sat.entry");
    sat_chk(10'd300, 2'b01, 8'hFF, "sat.300");
    sat_chk(10'd300, 2'b10, 8'd200, "sat.200");
    sat_chk(10'd255, 2'b01, 8'd255, "sat.255");
    sat_chk(10'd256, 2'b01, 8'hFF, "sat.256");
    sat_chk(10'd256, 2'b11, 8'hFF, "sat.prio");

    // leader scanner
    bus.cand_votes = {8'd2, 8'd9, 8'd9, 8'd5};
    for (int i = 0; i < 12; i++) cyc(8'h00, 1'b0, "ldr.wait");
`ifdef LEADER_DISP_EN
    chk("ldr.idx", 32'(bus.leader_idx), 1);
    chk("ldr.val", 32'(bus.leader_valid), 1);
`else
    chk("ldr.idx", 32'(bus.leader_idx), 0);
    chk("ldr.val", 32'(bus.leader_valid), 0);
`endif
    bus.cand_votes = '0;
    for (int i = 0; i < 12; i++) cyc(8'h00, 1'b0, "ldr.wait0");
    chk("ldr.zero", 32'(bus.leader_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
